// File: rtl/bonus_sched_pkg.sv
// Shared definitions for the bonus scheduler: random bus width,
// parameter defaults and FSM state encodings.
`ifndef RAND_WIDTH
`define RAND_WIDTH 16
`endif

package bonus_sched_pkg;

    localparam int DEF_COOL_BASE      = 600;
    localparam int DEF_COOL_RAND_BITS = 8;
    localparam int DEF_DOUBLE_FRAMES  = 900;
    localparam int DEF_BOMB_MAX       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOL  = 2'd1,
        ST_SPAWN = 2'd2,
        ST_LIVE  = 2'd3
    } state_t;

endpackage

// File: rtl/bonus_sched_vsync_tick.sv
// Brings v_sync into the clk_run domain and emits a one-cycle
// frame tick on each synchronised rising edge.
module vsync_tick (
    input  logic clk_run,
    input  logic rst,
    input  logic v_sync_i,
    output logic tick_o
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], v_sync_i};
            r_prev <= r_sync[1];
        end
    end

    assign tick_o = r_sync[1] & ~r_prev;

endmodule

// File: rtl/bonus_sched.sv
// Bonus item scheduler: frame-based spawn cooldown, double-shoot
// timer and bomb stock with key-edge firing.
module bonus_sched
    import bonus_sched_pkg::*;
#(
    parameter int COOL_BASE      = DEF_COOL_BASE,
    parameter int COOL_RAND_BITS = DEF_COOL_RAND_BITS,
    parameter int DOUBLE_FRAMES  = DEF_DOUBLE_FRAMES,
    parameter int BOMB_MAX       = DEF_BOMB_MAX
) (
    input  logic                   clk_run,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [`RAND_WIDTH-1:0] rand_i,
    input  logic                   v_sync_i,
    input  logic                   bonus_alive_i,
    input  logic                   pick_bomb_i,
    input  logic                   pick_double_i,
    input  logic                   bomb_key_i,
    output logic                   spawn_o,
    output logic                   spawn_type_o,
    output logic                   double_shoot_o,
    output logic [1:0]             bomb_cnt_o,
    output logic                   bomb_fire_o
);

    localparam int COOL_W = $clog2(COOL_BASE + (1 << COOL_RAND_BITS) + 1);

    state_t              r_state, w_state_nx;
    logic [COOL_W-1:0]   r_cool, w_cool_nx, w_cool_load;
    logic                r_type, w_type_nx;
    logic [9:0]          r_dbl;
    logic [1:0]          r_bomb, w_bomb_nx;
    logic [2:0]          w_bomb_sum;
    logic                r_key_d, r_fire;
    logic                w_tick, w_active, w_pick_b, w_use;

    vsync_tick u_tick (
        .clk_run (clk_run),
        .rst     (rst),
        .v_sync_i(v_sync_i),
        .tick_o  (w_tick)
    );

    assign w_cool_load = COOL_W'(COOL_BASE)
                       + COOL_W'(rand_i[COOL_RAND_BITS-1:0]);

    always_comb begin
        w_state_nx = r_state;
        w_cool_nx  = r_cool;
        w_type_nx  = r_type;
        if (!en_i) begin
            w_state_nx = ST_IDLE;
            w_cool_nx  = '0;
            w_type_nx  = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_COOL;
                    w_cool_nx  = w_cool_load;
                end
                ST_COOL: begin
                    if (w_tick) begin
                        if (r_cool != '0) begin
                            w_cool_nx = r_cool - COOL_W'(1);
                        end else begin
                            w_state_nx = ST_SPAWN;
                            w_type_nx  = rand_i[0];
                        end
                    end
                end
                ST_SPAWN: w_state_nx = ST_LIVE;
                ST_LIVE: begin
                    if (w_tick && !bonus_alive_i) begin
                        w_state_nx = ST_COOL;
                        w_cool_nx  = w_cool_load;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cool  <= '0;
            r_type  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cool  <= w_cool_nx;
            r_type  <= w_type_nx;
        end
    end

    // Pickups and key presses only count while the game is scheduling
    assign w_active   = (r_state != ST_IDLE);
    assign w_pick_b   = pick_bomb_i & w_active;
    assign w_use      = bomb_key_i & ~r_key_d & w_active
                      & ((r_bomb != 2'd0) | w_pick_b);
    assign w_bomb_sum = {1'b0, r_bomb} + {2'b00, w_pick_b} - {2'b00, w_use};
    assign w_bomb_nx  = (w_bomb_sum > 3'(BOMB_MAX)) ? 2'(BOMB_MAX)
                                                    : w_bomb_sum[1:0];

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            r_dbl   <= '0;
            r_bomb  <= '0;
            r_key_d <= 1'b0;
            r_fire  <= 1'b0;
        end else begin
            r_key_d <= bomb_key_i;
            if (!en_i) begin
                r_dbl  <= '0;
                r_bomb <= '0;
                r_fire <= 1'b0;
            end else begin
                r_bomb <= w_bomb_nx;
                r_fire <= w_use;
                if (pick_double_i && w_active) begin
                    r_dbl <= 10'(DOUBLE_FRAMES);
                end else if (w_tick && r_dbl != '0) begin
                    r_dbl <= r_dbl - 10'd1;
                end
            end
        end
    end

    assign spawn_o        = (r_state == ST_SPAWN);
    assign spawn_type_o   = r_type;
    assign double_shoot_o = (r_dbl != '0);
    assign bomb_cnt_o     = r_bomb;
    assign bomb_fire_o    = r_fire;

endmodule

// File: tb/tb_bonus_sched.sv
// Directed bench for bonus_sched: bomb vector table plus
// hand-written frame sequences for cooldown, double and abort.
`ifndef RAND_WIDTH
`define RAND_WIDTH 16
`endif

module tb_bonus_sched;

    logic                   clk_run = 1'b0;
    logic                   rst = 1'b1;
    logic                   en_i = 1'b0;
    logic [`RAND_WIDTH-1:0] rand_i = '0;
    logic                   v_sync_i = 1'b0;
    logic                   bonus_alive_i = 1'b0;
    logic                   pick_bomb_i = 1'b0;
    logic                   pick_double_i = 1'b0;
    logic                   bomb_key_i = 1'b0;
    logic                   spawn_o, spawn_type_o, double_shoot_o;
    logic [1:0]             bomb_cnt_o;
    logic                   bomb_fire_o;

    int n_vec = 0;
    int n_bad = 0;
    int n_spawn = 0;
    int n_fire;

    bonus_sched #(
        .COOL_BASE     (2),
        .COOL_RAND_BITS(2),
        .DOUBLE_FRAMES (3),
        .BOMB_MAX      (3)
    ) dut (
        .clk_run       (clk_run),
        .rst           (rst),
        .en_i          (en_i),
        .rand_i        (rand_i),
        .v_sync_i      (v_sync_i),
        .bonus_alive_i (bonus_alive_i),
        .pick_bomb_i   (pick_bomb_i),
        .pick_double_i (pick_double_i),
        .bomb_key_i    (bomb_key_i),
        .spawn_o       (spawn_o),
        .spawn_type_o  (spawn_type_o),
        .double_shoot_o(double_shoot_o),
        .bomb_cnt_o    (bomb_cnt_o),
        .bomb_fire_o   (bomb_fire_o)
    );

    always #5 clk_run = ~clk_run;

    always @(negedge clk_run) begin
        if (spawn_o) n_spawn++;
    end

    typedef struct {
        logic       pick;
        logic       key;
        logic [1:0] cnt;
        logic       fire;
    } bvec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en_i = 1'b0;
        v_sync_i = 1'b0;
        bonus_alive_i = 1'b0;
        pick_bomb_i = 1'b0;
        pick_double_i = 1'b0;
        bomb_key_i = 1'b0;
        repeat (2) @(negedge clk_run);
        rst = 1'b0;
        @(negedge clk_run);
        n_spawn = 0;
    endtask

    task automatic frame();
        v_sync_i = 1'b1;
        repeat (4) @(negedge clk_run);
        v_sync_i = 1'b0;
        repeat (4) @(negedge clk_run);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // Double pick lands in the same cycle the frame tick is consumed
    task automatic frame_with_dbl();
        v_sync_i = 1'b1;
        repeat (2) @(negedge clk_run);
        pick_double_i = 1'b1;
        @(negedge clk_run);
        pick_double_i = 1'b0;
        @(negedge clk_run);
        v_sync_i = 1'b0;
        repeat (4) @(negedge clk_run);
    endtask

    task automatic pulse_bomb();
        pick_bomb_i = 1'b1;
        @(negedge clk_run);
        pick_bomb_i = 1'b0;
    endtask

    task automatic pulse_dbl();
        pick_double_i = 1'b1;
        @(negedge clk_run);
        pick_double_i = 1'b0;
    endtask

    bvec_t tbl[25];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'd1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'd2, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'd3, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'd3, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd2, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'd2, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2'd2, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 2'd2, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 2'd3, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 2'd3, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 2'd3, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 2'd2, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 2'd2, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 2'd1, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 2'd1, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 2'd0, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 2'd0, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 2'd0, 1'b1};
        tbl[22] = '{1'b0, 1'b0, 2'd0, 1'b0};
        tbl[23] = '{1'b0, 1'b1, 2'd0, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 2'd0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk_run);
        chk("rst_spawn", spawn_o, 0);
        chk("rst_type", spawn_type_o, 0);
        chk("rst_double", double_shoot_o, 0);
        chk("rst_cnt", bomb_cnt_o, 0);
        chk("rst_fire", bomb_fire_o, 0);

        // Bomb stock table, no frame ticks, FSM parked in COOL
        do_reset();
        en_i = 1'b1;
        @(negedge clk_run);
        for (int i = 0; i < 25; i++) begin
            pick_bomb_i = tbl[i].pick;
            bomb_key_i  = tbl[i].key;
            @(negedge clk_run);
            chk($sformatf("bomb_cnt[%0d]", i), bomb_cnt_o, tbl[i].cnt);
            chk($sformatf("bomb_fire[%0d]", i), bomb_fire_o, tbl[i].fire);
        end
        pick_bomb_i = 1'b0;

        // Key held for 10 cycles fires once
        pulse_bomb();
        pulse_bomb();
        chk("hold_pre_cnt", bomb_cnt_o, 2);
        n_fire = 0;
        bomb_key_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_run);
            if (bomb_fire_o) n_fire++;
        end
        bomb_key_i = 1'b0;
        @(negedge clk_run);
        chk("hold_fires", n_fire, 1);
        chk("hold_cnt", bomb_cnt_o, 1);

        // Spawn cadence: rand=1 gives a 4-tick cooldown
        do_reset();
        rand_i = 1;
        en_i = 1'b1;
        @(negedge clk_run);
        frames(3);
        chk("spawn1_early", n_spawn, 0);
        frame();
        chk("spawn1", n_spawn, 1);
        chk("spawn1_type", spawn_type_o, 1);
        frame();
        chk("type_held", spawn_type_o, 1);
        rand_i = 2;
        frames(3);
        chk("spawn2_early", n_spawn, 1);
        frame();
        chk("spawn2", n_spawn, 2);
        chk("spawn2_type", spawn_type_o, 0);

        // Bonus stays alive for 5 ticks
        bonus_alive_i = 1'b1;
        frames(5);
        chk("alive_hold", n_spawn, 2);
        rand_i = 1;
        bonus_alive_i = 1'b0;
        frame();
        frames(3);
        chk("spawn3_early", n_spawn, 2);
        frame();
        chk("spawn3", n_spawn, 3);
        chk("spawn3_type", spawn_type_o, 1);

        // Double timer restart
        do_reset();
        en_i = 1'b1;
        @(negedge clk_run);
        chk("dbl_idle", double_shoot_o, 0);
        pulse_dbl();
        chk("dbl_on", double_shoot_o, 1);
        frames(2);
        pulse_dbl();
        frames(2);
        chk("dbl_t4", double_shoot_o, 1);
        frame();
        chk("dbl_t5_off", double_shoot_o, 0);
        frame_with_dbl();
        frames(2);
        chk("dbl_coinc_t2", double_shoot_o, 1);
        frame();
        chk("dbl_coinc_off", double_shoot_o, 0);

        // en_i drop mid-COOL
        do_reset();
        rand_i = 1;
        en_i = 1'b1;
        @(negedge clk_run);
        pulse_bomb();
        pulse_bomb();
        pulse_dbl();
        frame();
        chk("abort_pre_cnt", bomb_cnt_o, 2);
        chk("abort_pre_dbl", double_shoot_o, 1);
        en_i = 1'b0;
        @(negedge clk_run);
        chk("abort_spawn", spawn_o, 0);
        chk("abort_type", spawn_type_o, 0);
        chk("abort_dbl", double_shoot_o, 0);
        chk("abort_cnt", bomb_cnt_o, 0);
        chk("abort_fire", bomb_fire_o, 0);

        // Async reset mid-LIVE
        en_i = 1'b1;
        @(negedge clk_run);
        frames(4);
        bonus_alive_i = 1'b1;
        pulse_bomb();
        pulse_dbl();
        chk("live_pre_type", spawn_type_o, 1);
        chk("live_pre_cnt", bomb_cnt_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_type", spawn_type_o, 0);
        chk("arst_dbl", double_shoot_o, 0);
        chk("arst_cnt", bomb_cnt_o, 0);
        chk("arst_spawn", spawn_o, 0);
        @(negedge clk_run);
        rst = 1'b0;
        @(negedge clk_run);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
